// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read stage, the
// multiply/divide unit and the write-back port.
interface muldiv_unit_if #(
  parameter int XLEN = 64
);
  // Strict valid/ready on both sides: a transfer happens on a rising edge
  // where valid and ready are both high; the producer holds valid and its
  // payload unchanged until that edge, and valid never waits on ready.
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [4:0]      in_rd_addr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd_addr;
  logic [XLEN-1:0] out_rd_data;

  modport master (
    output in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd_addr,
    output flush, out_ready,
    input  in_ready, out_valid, out_rd_addr, out_rd_data
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1_data, in_rs2_data, in_rd_addr,
    input  flush, out_ready,
    output in_ready, out_valid, out_rd_addr, out_rd_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, a single operation in flight.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave io,
  output logic [1:0]   dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              prep;
  logic              neg_res;
  logic              div_zero;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   bq;

  logic              is_div;
  logic              is_rem;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   fin_res;

  assign dbg_state = state;

  // During the prep cycle lo/bq still hold the raw rs1/rs2 values.
  always_comb begin
    is_div = op[2];
    is_rem = op[2] & op[1];
    a_sgn  = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    b_sgn  = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
    a_neg  = a_sgn & lo[XLEN-1];
    b_neg  = b_sgn & bq[XLEN-1];
    mag_a  = a_neg ? -lo : lo;
    mag_b  = b_neg ? -bq : bq;
  end

  // hi:lo is the product accumulator for multiply and remainder:quotient
  // for divide; bq holds the multiplicand or the divisor magnitude.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ok    = div_shift >= {1'b0, bq};
    if (is_div) begin
      step_hi = div_ok ? (div_shift[XLEN-1:0] - bq) : div_shift[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_s = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    q_s    = neg_res ? -step_lo : step_lo;
    r_s    = neg_res ? -step_hi : step_hi;
    case (op)
      3'd0:             fin_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin_res = q_s;
      default:          fin_res = r_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      prep           <= 1'b0;
      neg_res        <= 1'b0;
      div_zero       <= 1'b0;
      op             <= '0;
      rd             <= '0;
      hi             <= '0;
      lo             <= '0;
      bq             <= '0;
      io.in_ready    <= 1'b1;
      io.out_valid   <= 1'b0;
      io.out_rd_addr <= '0;
      io.out_rd_data <= '0;
    end else if (io.flush) begin
      state        <= S_IDLE;
      cnt          <= '0;
      prep         <= 1'b0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            op          <= io.in_funct3;
            rd          <= io.in_rd_addr;
            lo          <= io.in_rs1_data;
            bq          <= io.in_rs2_data;
            cnt         <= CNT_W'(XLEN);
            prep        <= 1'b1;
            io.in_ready <= 1'b0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (prep) begin
            // Magnitude conversion gets its own cycle so the operand negate
            // is not in series with the register-file read path.
            prep     <= 1'b0;
            div_zero <= is_div & (bq == '0);
            neg_res  <= is_rem ? a_neg : (a_neg ^ b_neg);
            hi       <= (is_div & (bq == '0)) ? lo : '0;
            lo       <= is_div ? mag_a : mag_b;
            bq       <= is_div ? mag_b : mag_a;
          end else if (div_zero) begin
            io.out_rd_data <= op[1] ? hi : '1;
            io.out_rd_addr <= rd;
            io.out_valid   <= 1'b1;
            cnt            <= '0;
            state          <= S_DONE;
          end else begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              io.out_rd_data <= fin_res;
              io.out_rd_addr <= rd;
              io.out_valid   <= 1'b1;
              state          <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          io.in_ready  <= 1'b1;
          io.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
